case_match_engine: RTL
======================

# case_match_engine

Parametrised, sequential evaluator of Verilog `case` item matching with mixed operand widths and signedness. Items are written into a programmable table. A selector is then accepted through a valid/ready handshake. The engine scans items in priority order, one per cycle, and returns the first matching item index or the default outcome. It is the hardware counterpart of the frontend's non-constant case evaluation rules and serves as a synthesizable regression target for those rules.

## Interface
- SEL_W, 3, selector width in bits (>=1)
- ITEM_W, 3, maximum item width in bits (>=1)
- NUM_ITEMS, 4, table depth (>=1)
- IDX_W, max(1, clog2(NUM_ITEMS)), derived
- WID_W, clog2(ITEM_W+1), derived
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- cfg_we  in  1  table write strobe
- cfg_idx  in  IDX_W  item slot to write
- cfg_val  in  ITEM_W  item value; only the low cfg_width bits are meaningful
- cfg_width  in  WID_W  declared item width; 0 is treated as 1, values >ITEM_W are treated as ITEM_W
- cfg_signed  in  1  item is a signed literal
- cfg_en  in  1  item slot enabled
- dflt_we  in  1  write strobe for the default flag
- dflt_en  in  1  case has a default branch
- busy  out  1  high in SCAN and DONE; cfg and dflt writes are ignored while high
- in_valid  in  1  selector request valid
- in_ready  out  1  high only in IDLE
- in_sel  in  SEL_W  selector value
- in_sel_signed  in  1  selector is signed
- out_valid  out  1  result valid
- out_ready  in  1  result consumer ready
- out_hit  out  1  an enabled item matched
- out_idx  out  IDX_W  index of the first matching item; 0 when there is no hit
- out_default  out  1  no hit and a default branch exists

## Operation
- Table entry per slot: value, width, signed, en. Reset clears every en, clears the default flag, and zeroes all values.
- States:
  - IDLE: `in_ready=1`. A handshake (`in_valid && in_ready`) latches `in_sel` and the context signedness, sets i=0, and moves to SCAN.
- Context signedness, fixed at accept: `ctx_signed = in_sel_signed AND (signed of every enabled item)`. Disabled items do not participate.
- Operand extension:
  - The item value is masked to its declared width w. Bits at and above w are replaced by bit w-1 when ctx_signed, otherwise by 0.
  - The selector is extended the same way from SEL_W.
  - Both operands are compared at M = max(SEL_W, ITEM_W) bits. This is equivalent to comparing at the true context width because extension is idempotent.
- SCAN: examine item i for one cycle.
  - If en[i] and the operands are equal: `hit=1`, `idx=i`, go to DONE.
  - Otherwise, if i = NUM_ITEMS-1: `hit=0`, `idx=0`, `default=dflt_flag`, go to DONE.
  - Otherwise i++.
  - Disabled slots still consume a cycle.
- DONE: `out_valid=1` and the result registers are held stable. When `out_valid && out_ready`, go to IDLE.
- Table writes take effect on the next edge and only while in IDLE. Writes while busy are dropped silently; the latched ctx_signed is unaffected.
- `dflt_we` has the same rule as table writes.

## Timing
- Reset values: `in_ready=1`, `busy=0`, `out_valid=0`, `out_hit=0`, `out_idx=0`, `out_default=0`, state IDLE.
- Accept at edge T:
  - Item i is examined in cycle T+1+i.
  - On a first match at k, out_valid rises at edge T+2+k.
  - With no match, out_valid rises at edge T+1+NUM_ITEMS.
- Minimum request spacing is latency+1 cycles. No new request is accepted in the cycle out_valid drops.
- Once out_valid is high, the outputs must not change until the handshake completes.
- `rst` mid-SCAN or mid-DONE: next cycle is IDLE, out_valid=0, and the table is cleared. Reset takes priority over any simultaneous handshake or write.
- A cfg_we and an in_valid handshake in the same IDLE cycle: the write lands, and the scan uses the updated table.

## Test plan
- SEL_W=2, ITEM_W=3. Item0 = 1'b0 unsigned; sel = 2'b00 unsigned -> out_hit=1, out_idx=0, out_valid 2 cycles after accept.
- Item0 = 2'sb01 signed, item1 = 1'sb1 signed, sel = 2'sb11 signed -> ctx signed, item1 extends to 11 -> out_hit=1, out_idx=1, latency 3.
- Item0 = 1'b0 unsigned, item1 = 1'sb1 signed, default enabled, sel = 2'sb11 -> ctx unsigned, item1 extends to 01 -> out_hit=0, out_default=1, latency NUM_ITEMS+1=5.
- No default, no enabled items, sel = 2'b10 -> out_hit=0, out_default=0, out_idx=0.
- Hold out_ready low for 5 cycles in DONE and issue a cfg_we during that time -> outputs stable, in_ready=0, busy=1, write dropped. A rerun gives the same result.
- Assert rst in SCAN at i=2 -> the next cycle has out_valid=0 and in_ready=1. A repeat of any earlier request then returns out_hit=0 (table cleared).

Source files
------------

// File: rtl/case_match_engine_if.sv
// case_match_engine_if
// Groups the table-programming, request and result signals of
// case_match_engine into one bundle.
//   cfg_*        : table slot write (value, declared width, signedness, enable)
//   dflt_*       : default-branch flag write
//   busy         : engine is scanning or holding a result
//   in_*         : selector request, valid/ready handshake
//   out_*        : result, valid/ready handshake
// Modports: master drives requests/config, slave is the engine.
interface case_match_engine_if #(
  parameter int SEL_W     = 3,
  parameter int ITEM_W    = 3,
  parameter int NUM_ITEMS = 4
);
  localparam int IDX_W = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;
  localparam int WID_W = $clog2(ITEM_W + 1);

  logic              cfg_we;
  logic [IDX_W-1:0]  cfg_idx;
  logic [ITEM_W-1:0] cfg_val;
  logic [WID_W-1:0]  cfg_width;
  logic              cfg_signed;
  logic              cfg_en;
  logic              dflt_we;
  logic              dflt_en;
  logic              busy;
  logic              in_valid;
  logic              in_ready;
  logic [SEL_W-1:0]  in_sel;
  logic              in_sel_signed;
  logic              out_valid;
  logic              out_ready;
  logic              out_hit;
  logic [IDX_W-1:0]  out_idx;
  logic              out_default;

  modport master (
    output cfg_we, cfg_idx, cfg_val, cfg_width, cfg_signed, cfg_en,
    output dflt_we, dflt_en,
    output in_valid, in_sel, in_sel_signed, out_ready,
    input  busy, in_ready, out_valid, out_hit, out_idx, out_default
  );

  modport slave (
    input  cfg_we, cfg_idx, cfg_val, cfg_width, cfg_signed, cfg_en,
    input  dflt_we, dflt_en,
    input  in_valid, in_sel, in_sel_signed, out_ready,
    output busy, in_ready, out_valid, out_hit, out_idx, out_default
  );
endinterface

// File: rtl/case_match_engine.sv
// case_match_engine
// Sequential evaluator of case-item matching with mixed widths/signedness.
// A table of NUM_ITEMS items is programmed while idle; an accepted selector
// is compared against one item per cycle in priority order, and the first
// enabled match (or the default outcome) is presented until acknowledged.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset (clears FSM, table, default flag)
//   bus  : case_match_engine_if.slave (config, request, result)
module case_match_engine #(
  parameter int SEL_W     = 3,
  parameter int ITEM_W    = 3,
  parameter int NUM_ITEMS = 4
) (
  input logic                 clk,
  input logic                 rst,
  case_match_engine_if.slave  bus
);
  localparam int IDX_W = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;
  localparam int WID_W = $clog2(ITEM_W + 1);
  localparam int M     = (SEL_W > ITEM_W) ? SEL_W : ITEM_W;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t state_q, state_d;

  logic [ITEM_W-1:0]    tbl_val [NUM_ITEMS];
  logic [WID_W-1:0]     tbl_wid [NUM_ITEMS];
  logic [NUM_ITEMS-1:0] tbl_sgn;
  logic [NUM_ITEMS-1:0] tbl_en;
  logic                 dflt_q;

  logic [SEL_W-1:0]     sel_q;
  logic                 sel_sgn_q;
  logic [IDX_W-1:0]     i_q;

  logic                 hit_q;
  logic [IDX_W-1:0]     idx_q;
  logic                 dflt_out_q;

  logic                 ctx_signed;
  logic                 match;
  logic                 last;

  // Width 0 behaves as 1, anything wider than ITEM_W as ITEM_W.
  function automatic logic [WID_W-1:0] clamp_w(input logic [WID_W-1:0] w);
    if (w == '0) return WID_W'(1);
    if (32'(w) > 32'(ITEM_W)) return WID_W'(ITEM_W);
    return w;
  endfunction

  // Mask the item to its declared width, then fill upward with its top
  // declared bit (signed context) or zero.
  function automatic logic [M-1:0] ext_item(input logic [ITEM_W-1:0] v,
                                            input logic [WID_W-1:0]  w,
                                            input logic              s);
    logic [M-1:0] vz;
    logic [M-1:0] r;
    logic         msb;
    vz  = M'(v);
    msb = 1'b0;
    r   = '0;
    for (int unsigned b = 0; b < M; b++)
      if (b + 1 == 32'(w)) msb = vz[b];
    for (int unsigned b = 0; b < M; b++)
      r[b] = (b < 32'(w)) ? vz[b] : (s & msb);
    return r;
  endfunction

  function automatic logic [M-1:0] ext_sel(input logic [SEL_W-1:0] v,
                                           input logic             s);
    logic [M-1:0] vz;
    logic [M-1:0] r;
    vz = M'(v);
    r  = '0;
    for (int unsigned b = 0; b < M; b++)
      r[b] = (b < 32'(SEL_W)) ? vz[b] : (s & v[SEL_W-1]);
    return r;
  endfunction

  // The table is frozen outside IDLE, so evaluating the context from the
  // live table during SCAN equals latching it at accept, and it also picks
  // up a write that lands on the accept edge.
  always_comb begin
    ctx_signed = sel_sgn_q;
    for (int unsigned n = 0; n < NUM_ITEMS; n++)
      if (tbl_en[n] && !tbl_sgn[n]) ctx_signed = 1'b0;
  end

  always_comb begin
    match = tbl_en[i_q] &&
            (ext_item(tbl_val[i_q], tbl_wid[i_q], ctx_signed) ==
             ext_sel(sel_q, ctx_signed));
    last  = (i_q == IDX_W'(NUM_ITEMS - 1));
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)       state_d = SCAN;
      SCAN:    if (match || last)      state_d = DONE;
      DONE:    if (bus.out_ready)      state_d = IDLE;
      default:                         state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.in_ready    = (state_q == IDLE);
    bus.busy        = (state_q != IDLE);
    bus.out_valid   = (state_q == DONE);
    bus.out_hit     = hit_q;
    bus.out_idx     = idx_q;
    bus.out_default = dflt_out_q;
  end

  // Table, request latch, scan index and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned n = 0; n < NUM_ITEMS; n++) begin
        tbl_val[n] <= '0;
        tbl_wid[n] <= '0;
      end
      tbl_sgn    <= '0;
      tbl_en     <= '0;
      dflt_q     <= 1'b0;
      sel_q      <= '0;
      sel_sgn_q  <= 1'b0;
      i_q        <= '0;
      hit_q      <= 1'b0;
      idx_q      <= '0;
      dflt_out_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.cfg_we && (32'(bus.cfg_idx) < 32'(NUM_ITEMS))) begin
            tbl_val[bus.cfg_idx] <= bus.cfg_val;
            tbl_wid[bus.cfg_idx] <= clamp_w(bus.cfg_width);
            tbl_sgn[bus.cfg_idx] <= bus.cfg_signed;
            tbl_en[bus.cfg_idx]  <= bus.cfg_en;
          end
          if (bus.dflt_we) dflt_q <= bus.dflt_en;
          if (bus.in_valid) begin
            sel_q     <= bus.in_sel;
            sel_sgn_q <= bus.in_sel_signed;
            i_q       <= '0;
          end
        end
        SCAN: begin
          if (match) begin
            hit_q      <= 1'b1;
            idx_q      <= i_q;
            dflt_out_q <= 1'b0;
          end else if (last) begin
            hit_q      <= 1'b0;
            idx_q      <= '0;
            dflt_out_q <= dflt_q;
          end else begin
            i_q <= i_q + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule
